usb_pkt_rx: RTL and testbench

// - Packet decoder directly downstream of the UTM receive side. Consumes the UTMI rx byte stream.
// - Validates the PID check nibble, CRC5 (tokens) and CRC16 (data), and checks packet lengths.
// - Presents decoded token fields, handshake PIDs and a CRC-stripped data byte stream to the

---
 rtl/usb_pkt_pkg.sv | 39 +++
 rtl/usb_pkt_rx_if.sv | 32 +++
 rtl/usb_crc16.sv | 24 ++
 rtl/usb_pkt_rx.sv | 171 +++++++++++++++++
 tb/tb_usb_pkt_rx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkt_pkg.sv
// usb_pkt_pkg: PID/error codes, CRC residuals and CRC5 helper shared by rx and tx packet logic
package usb_pkt_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'h1,
        PID_IN    = 4'h9,
        PID_SOF   = 4'h5,
        PID_SETUP = 4'hD,
        PID_DATA0 = 4'h3,
        PID_DATA1 = 4'hB,
        PID_DATA2 = 4'h7,
        PID_MDATA = 4'hF,
        PID_ACK   = 4'h2,
        PID_NAK   = 4'hA,
        PID_STALL = 4'hE,
        PID_NYET  = 4'h6
    } pid_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_PID   = 3'd1,
        ERR_CRC   = 3'd2,
        ERR_LEN   = 3'd3,
        ERR_RXERR = 3'd4
    } err_t;

    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // bits enter LSB-first; register kept in MSB-first polynomial form
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = {c[3:0], 1'b0} ^ ((data[i] ^ c[4]) ? 5'h05 : 5'h00);
        return c;
    endfunction

endpackage

// File: rtl/usb_pkt_rx_if.sv
// usb_pkt_rx_if: UTMI receive stream in, decoded packet events out
interface usb_pkt_rx_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_active;
    logic        rx_error;
    logic        pid_valid;
    logic [3:0]  pid;
    logic        tok_valid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [10:0] frame_num;
    logic        hsk_valid;
    logic        dat_tvalid;
    logic [7:0]  dat_tdata;
    logic        dat_done;
    logic        dat_ok;
    logic        pkt_err;
    logic [2:0]  err_code;

    modport master (
        output rx_data, rx_valid, rx_active, rx_error,
        input  pid_valid, pid, tok_valid, tok_addr, tok_endp, frame_num, hsk_valid,
               dat_tvalid, dat_tdata, dat_done, dat_ok, pkt_err, err_code
    );

    modport slave (
        input  rx_data, rx_valid, rx_active, rx_error,
        output pid_valid, pid, tok_valid, tok_addr, tok_endp, frame_num, hsk_valid,
               dat_tvalid, dat_tdata, dat_done, dat_ok, pkt_err, err_code
    );
endinterface

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wide USB CRC16, bits taken LSB-first, poly 16'h8005
module usb_crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);
    logic [15:0] w_next;

    // fold one byte into the running remainder
    always_comb begin
        w_next = crc;
        for (int i = 0; i < 8; i++)
            w_next = {w_next[14:0], 1'b0} ^ ((data[i] ^ w_next[15]) ? 16'h8005 : 16'h0000);
    end

    // remainder register; init takes priority over a byte update
    always_ff @(posedge clk) begin
        if (rst || init) crc <= 16'hFFFF;
        else if (en)     crc <= w_next;
    end
endmodule

// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: decodes UTMI rx bytes into PID, token, handshake and CRC-stripped data events
module usb_pkt_rx import usb_pkt_pkg::*; #(
    parameter int MAX_PKT = 64
) (
    input logic         clk,
    input logic         rst,
    usb_pkt_rx_if.slave bus
);
    localparam int CW = $clog2(MAX_PKT + 4);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PKT + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_PKT + 3);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PID  = 3'd1;
    localparam logic [2:0] S_TOK  = 3'd2;
    localparam logic [2:0] S_DAT  = 3'd3;
    localparam logic [2:0] S_HSK  = 3'd4;
    localparam logic [2:0] S_DROP = 3'd5;

    function automatic logic [2:0] pid_state(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP:       return S_TOK;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: return S_DAT;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:     return S_HSK;
            default:                                   return S_DROP;
        endcase
    endfunction

    logic [2:0]    r_state;
    logic          r_act_q;
    logic [CW-1:0] r_cnt;
    logic [10:0]   r_tok;
    logic [4:0]    r_crc5;
    logic [7:0]    r_d0, r_d1;
    logic [15:0]   w_crc16;

    // a byte carrying rx_error is discarded
    logic w_acc, w_rise, w_eop, w_pid_ok, w_tok_ok, w_dat_ok, w_active;
    assign w_acc    = bus.rx_valid & bus.rx_active & ~bus.rx_error;
    assign w_rise   = bus.rx_active & ~r_act_q;
    assign w_eop    = ~bus.rx_active & r_act_q;
    assign w_pid_ok = bus.rx_data[7:4] == ~bus.rx_data[3:0];
    assign w_tok_ok = (r_cnt == CNT_TWO) && (r_crc5 == CRC5_RESIDUAL);
    assign w_dat_ok = (r_cnt >= CNT_TWO) && (w_crc16 == CRC16_RESIDUAL);
    assign w_active = (r_state != S_IDLE) && (r_state != S_DROP);

    usb_crc16 u_crc16 (
        .clk  (clk),
        .rst  (rst),
        .init (r_state == S_PID && w_acc),
        .en   (r_state == S_DAT && w_acc),
        .data (bus.rx_data),
        .crc  (w_crc16)
    );

    // packet FSM; pulses default low, held fields change only on their strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_act_q        <= 1'b1;
            r_cnt          <= '0;
            r_tok          <= '0;
            r_crc5         <= 5'h1F;
            r_d0           <= '0;
            r_d1           <= '0;
            bus.pid_valid  <= 1'b0;
            bus.pid        <= '0;
            bus.tok_valid  <= 1'b0;
            bus.tok_addr   <= '0;
            bus.tok_endp   <= '0;
            bus.frame_num  <= '0;
            bus.hsk_valid  <= 1'b0;
            bus.dat_tvalid <= 1'b0;
            bus.dat_tdata  <= '0;
            bus.dat_done   <= 1'b0;
            bus.dat_ok     <= 1'b0;
            bus.pkt_err    <= 1'b0;
            bus.err_code   <= ERR_NONE;
        end else begin
            r_act_q        <= bus.rx_active;
            bus.pid_valid  <= 1'b0;
            bus.tok_valid  <= 1'b0;
            bus.hsk_valid  <= 1'b0;
            bus.dat_tvalid <= 1'b0;
            bus.dat_done   <= 1'b0;
            bus.dat_ok     <= 1'b0;
            bus.pkt_err    <= 1'b0;
            bus.err_code   <= ERR_NONE;
            if (bus.rx_error && w_active) begin
                bus.pkt_err  <= 1'b1;
                bus.err_code <= ERR_RXERR;
                bus.dat_done <= r_state == S_DAT;
                r_state      <= S_DROP;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= w_rise ? S_PID : bus.rx_active ? S_DROP : S_IDLE;
                    S_PID: begin
                        if (w_acc && !w_pid_ok) begin
                            bus.pkt_err  <= 1'b1;
                            bus.err_code <= ERR_PID;
                            r_state      <= S_DROP;
                        end else if (w_acc) begin
                            bus.pid_valid <= 1'b1;
                            bus.pid       <= bus.rx_data[3:0];
                            r_cnt         <= '0;
                            r_crc5        <= 5'h1F;
                            r_state       <= pid_state(bus.rx_data[3:0]);
                        end else if (w_eop) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_TOK: begin
                        if (w_acc && r_cnt == CNT_TWO) begin
                            bus.pkt_err  <= 1'b1;
                            bus.err_code <= ERR_LEN;
                            r_state      <= S_DROP;
                        end else if (w_acc) begin
                            r_cnt  <= r_cnt + CW'(1);
                            r_crc5 <= crc5_byte(r_crc5, bus.rx_data);
                            if (r_cnt == '0) r_tok[7:0]  <= bus.rx_data;
                            else             r_tok[10:8] <= bus.rx_data[2:0];
                        end else if (w_eop) begin
                            bus.tok_valid <= w_tok_ok;
                            bus.pkt_err   <= !w_tok_ok;
                            bus.err_code  <= (r_cnt != CNT_TWO) ? ERR_LEN : w_tok_ok ? ERR_NONE : ERR_CRC;
                            if (w_tok_ok) begin
                                bus.tok_addr  <= r_tok[6:0];
                                bus.tok_endp  <= r_tok[10:7];
                                bus.frame_num <= r_tok;
                            end
                            r_state <= S_IDLE;
                        end
                    end
                    S_DAT: begin
                        if (w_acc && r_cnt == CNT_LIM) begin
                            bus.pkt_err  <= 1'b1;
                            bus.err_code <= ERR_LEN;
                            bus.dat_done <= 1'b1;
                            r_state      <= S_DROP;
                        end else if (w_acc) begin
                            r_cnt          <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
                            bus.dat_tvalid <= r_cnt >= CNT_TWO;
                            bus.dat_tdata  <= r_d1;
                            r_d1           <= r_d0;
                            r_d0           <= bus.rx_data;
                        end else if (w_eop) begin
                            bus.dat_done <= 1'b1;
                            bus.dat_ok   <= w_dat_ok;
                            bus.pkt_err  <= !w_dat_ok;
                            bus.err_code <= (r_cnt < CNT_TWO) ? ERR_LEN : w_dat_ok ? ERR_NONE : ERR_CRC;
                            r_state      <= S_IDLE;
                        end
                    end
                    S_HSK: begin
                        if (w_acc) begin
                            bus.pkt_err  <= 1'b1;
                            bus.err_code <= ERR_LEN;
                            r_state      <= S_DROP;
                        end else if (w_eop) begin
                            bus.hsk_valid <= 1'b1;
                            r_state       <= S_IDLE;
                        end
                    end
                    S_DROP:  r_state <= bus.rx_active ? S_DROP : S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_pkt_rx.sv
// tb_usb_pkt_rx: scoreboard bench for usb_pkt_rx with directed and random packets
module tb_usb_pkt_rx;
    localparam int MAX = 64;
    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [2:0]  k;
        logic [15:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_pkt_rx_if bus();
    usb_pkt_rx #(.MAX_PKT(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    ev_t   exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string kname[8] = '{"none", "pid", "tok", "hsk", "byte", "done", "err", "frame"};

    function automatic void push(input int k, input int v);
        ev_t e;
        e.k = 3'(k);
        e.v = 16'(v);
        exp_q.push_back(e);
    endfunction

    // reflected (right-shifting) CRC forms; a good packet leaves these residuals
    function automatic logic [15:0] crc16_ref(input bq_t b, input int s, input int n);
        logic [15:0] r;
        logic [7:0]  x;
        r = 16'hFFFF;
        for (int i = s; i < s + n; i++) begin
            x = b[i];
            for (int j = 0; j < 8; j++) r = (r[0] ^ x[j]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [4:0] crc5_ref(input logic [15:0] v, input int nb);
        logic [4:0] r;
        r = 5'h1F;
        for (int j = 0; j < nb; j++) r = (r[0] ^ v[j]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] pidb(input logic [3:0] p);
        return {~p, p};
    endfunction

    function automatic bq_t mk_token(input logic [3:0] p, input logic [10:0] v);
        bq_t b;
        logic [15:0] w;
        w = {~crc5_ref({5'b0, v}, 11), v};
        b.push_back(pidb(p));
        b.push_back(w[7:0]);
        b.push_back(w[15:8]);
        return b;
    endfunction

    function automatic bq_t mk_data(input logic [3:0] p, input int len);
        bq_t b;
        logic [15:0] c;
        b.push_back(pidb(p));
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        c = ~crc16_ref(b, 1, len);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        return b;
    endfunction

    // expected events from packet rules: PID class by low two bits, length and CRC limits
    function automatic void model(input bq_t b, input int err_at);
        logic [7:0]  pb, b1, b2;
        logic [3:0]  p;
        logic        err;
        int          n, m, emit;
        err = err_at >= 0 && err_at < b.size();
        n   = err ? err_at : b.size();
        if (n == 0) begin
            if (err) push(6, 4);
            return;
        end
        pb = b[0];
        p  = pb[3:0];
        if (pb[7:4] != ~pb[3:0]) begin
            push(6, 1);
            return;
        end
        push(1, p);
        m = n - 1;
        case (p[1:0])
            2'b01: begin
                if (m > 2) push(6, 3);
                else if (err) push(6, 4);
                else if (m != 2) push(6, 3);
                else begin
                    b1 = b[1];
                    b2 = b[2];
                    if (crc5_ref({b2, b1}, 16) != 5'h06) push(6, 2);
                    else begin
                        push(2, {b2[2:0], b1});
                        push(7, {b2[2:0], b1});
                    end
                end
            end
            2'b10: begin
                if (m > 0) push(6, 3);
                else if (err) push(6, 4);
                else push(3, p);
            end
            2'b11: begin
                emit = ((m > MAX + 2) ? MAX + 2 : m) - 2;
                for (int i = 0; i < emit; i++) push(4, b[1 + i]);
                if (m > MAX + 2) begin push(5, 0); push(6, 3); end
                else if (err) begin push(5, 0); push(6, 4); end
                else if (m < 2) begin push(5, 0); push(6, 3); end
                else if (crc16_ref(b, 1, m) != 16'hB001) begin push(5, 0); push(6, 2); end
                else push(5, 1);
            end
            default: ;
        endcase
    endfunction

    task automatic obs(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s: got %0h, required no event", kname[k], v);
        end else begin
            e = exp_q.pop_front();
            if (e.k != 3'(k) || e.v != 16'(v)) begin
                errors++;
                $display("FAIL %s: got %s=%0h, required %s=%0h", kname[k], kname[k], v, kname[e.k], e.v);
            end
        end
    endtask

    // monitor: every output strobe consumes the next expected event
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pid_valid)  obs(1, int'(bus.pid));
            if (bus.dat_tvalid) obs(4, int'(bus.dat_tdata));
            if (bus.tok_valid) begin
                obs(2, int'({bus.tok_endp, bus.tok_addr}));
                obs(7, int'(bus.frame_num));
            end
            if (bus.hsk_valid)  obs(3, int'(bus.pid));
            if (bus.dat_done)   obs(5, int'(bus.dat_ok));
            if (bus.pkt_err)    obs(6, int'(bus.err_code));
        end
    end

    task automatic check_zero(input string name);
        logic [43:0] o;
        o = {bus.pid_valid, bus.pid, bus.tok_valid, bus.tok_addr, bus.tok_endp, bus.frame_num,
             bus.hsk_valid, bus.dat_tvalid, bus.dat_tdata, bus.dat_done, bus.dat_ok,
             bus.pkt_err, bus.err_code};
        checks++;
        if (o != '0) begin
            errors++;
            $display("FAIL %s: outputs=%h, required 0", name, o);
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic e);
        @(negedge clk);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        bus.rx_error = e;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic send(input bq_t b, input int err_at);
        model(b, err_at);
        @(negedge clk);
        bus.rx_active = 1'b1;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        for (int i = 0; i < b.size(); i++) drive_byte(b[i], i == err_at);
        bus.rx_active = 1'b0;
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_hex(input logic [127:0] v, input int n, input int err_at);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(v[8*(n-1-i) +: 8]);
        send(b, err_at);
    endtask

    initial begin
        bq_t        b;
        int         ix;
        logic [3:0] tk[4] = '{4'h1, 4'h9, 4'h5, 4'hD};
        logic [3:0] dk[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
        logic [3:0] hk[4] = '{4'h2, 4'hA, 4'hE, 4'h6};
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        bus.rx_active = 1'b0;
        bus.rx_error  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        send_hex(128'h2D_00_10, 3, -1);
        send_hex(128'hC3_80_06_00_01_00_00_40_00_DD_94, 11, -1);
        send_hex(128'hC3_80_06_00_01_00_00_40_00_DD_95, 11, -1);
        send_hex(128'h4B_00_00, 3, -1);
        send_hex(128'h4B_00, 2, -1);
        send_hex(128'hD2, 1, -1);
        send_hex(128'hD2_00, 2, -1);
        send_hex(128'h3D, 1, -1);
        send_hex(128'hC3_80_06_00_01_00_00_40_00_DD_94, 11, 4);
        send_hex(128'h2D_00_10, 3, -1);
        send_hex(128'h0, 0, -1);
        send(mk_data(4'h3, MAX), -1);
        send(mk_data(4'hB, MAX + 1), -1);
        b = mk_token(4'h1, 11'h123);
        b.push_back(8'h00);
        send(b, -1);
        // reset while a DATA0 is in flight and rx_active stays high
        push(1, 3);
        @(negedge clk);
        bus.rx_active = 1'b1;
        drive_byte(8'hC3, 1'b0);
        drive_byte(8'h80, 1'b0);
        drive_byte(8'h06, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("rst_mid_packet");
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_rst");
        drive_byte(8'h00, 1'b0);
        drive_byte(8'h01, 1'b0);
        drive_byte(8'h00, 1'b0);
        bus.rx_active = 1'b0;
        repeat (3) @(negedge clk);
        send_hex(128'h2D_00_10, 3, -1);
        for (int t = 0; t < 120; t++) begin
            b.delete();
            case ($urandom_range(0, 9))
                0: send(mk_token(tk[$urandom_range(0, 3)], 11'($urandom)), -1);
                1: begin
                    b = mk_token(tk[$urandom_range(0, 3)], 11'($urandom));
                    ix = $urandom_range(1, 2);
                    b[ix] = b[ix] ^ 8'(1 << $urandom_range(0, 7));
                    send(b, -1);
                end
                2: begin
                    b.push_back(pidb(tk[$urandom_range(0, 3)]));
                    repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
                    send(b, -1);
                end
                3: send(mk_data(dk[$urandom_range(0, 3)], $urandom_range(0, 20)), -1);
                4: begin
                    b = mk_data(dk[$urandom_range(0, 3)], $urandom_range(1, 20));
                    ix = $urandom_range(1, b.size() - 1);
                    b[ix] = b[ix] ^ 8'(1 << $urandom_range(0, 7));
                    send(b, -1);
                end
                5: begin
                    b.push_back(pidb(hk[$urandom_range(0, 3)]));
                    if ($urandom_range(0, 1) == 1) b.push_back(8'($urandom));
                    send(b, -1);
                end
                6: begin
                    b.push_back(8'($urandom));
                    repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
                    send(b, -1);
                end
                7: begin
                    b = mk_data(dk[$urandom_range(0, 3)], $urandom_range(0, 12));
                    send(b, $urandom_range(0, b.size() - 1));
                end
                8: begin
                    b = mk_token(tk[$urandom_range(0, 3)], 11'($urandom));
                    send(b, $urandom_range(0, 2));
                end
                default: send(mk_data(dk[$urandom_range(0, 3)], $urandom_range(MAX - 2, MAX + 2)), -1);
            endcase
        end
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
